cpx_multiply_arbiter: RTL and testbench
=======================================

CPX_MULTIPLY_ARBITER -- requirements
Module: cpx_multiply_arbiter

Interface
REQ-001 Parameter DATA_BITS, default 8, signed width of each xi/xq/yi/yq operand.
REQ-002 Parameter OUT_BITS, default 17, signed width of each i_out/q_out result.
REQ-003 Parameter TAG_DEPTH, default 8, outstanding-transaction capacity; SHALL be a power of 2, at least 2.
REQ-004 clk  in  1  sole clock; all state updates on posedge.
REQ-005 n_reset  in  1  synchronous, active-low reset.
REQ-006 req0_tvalid / req1_tvalid  in  1  requester k operand valid.
REQ-007 req0_tready / req1_tready  out  1  requester k operand accepted.
REQ-008 req0_tdata / req1_tdata  in  4*DATA_BITS  packed {xi,xq,yi,yq}, xi in MSBs.
REQ-009 res0_tvalid / res1_tvalid  out  1  result for requester k valid.
REQ-010 res0_tready / res1_tready  in  1  requester k accepts result.
REQ-011 res0_tdata / res1_tdata  out  2*OUT_BITS  packed {i_out,q_out}.
REQ-012 mult_in_tvalid  out  1;  mult_in_tready  in  1;  mult_in_tdata  out  4*DATA_BITS: operand stream to the shared cpx_multiply.
REQ-013 mult_out_tvalid  in  1;  mult_out_tready  out  1;  mult_out_tdata  in  2*OUT_BITS: result stream from cpx_multiply.
REQ-014 tag_err  out  1  sticky: result arrived with no outstanding tag.

Function
REQ-015 Transfer on any stream occurs when tvalid and tready are both high at posedge clk.
REQ-016 Arbitration: round-robin; with both requests valid, grant goes to the requester not granted last; with one valid, grant goes to it.
REQ-017 Grant lock: once mult_in_tvalid is high without handshake, grant and mult_in_tdata SHALL hold unchanged until handshake, regardless of the other requester.
REQ-018 Requesters SHALL hold tvalid and tdata stable until accepted; the arbiter relies on this.
REQ-019 mult_in_tvalid = granted request valid AND tag FIFO not full; mult_in_tdata = granted requester tdata, zero-latency mux.
REQ-020 reqk_tready = (grant==k) AND mult_in_tready AND NOT full; never high for both requesters in one cycle.
REQ-021 On mult_in handshake: push grant index k into tag FIFO; last-grant pointer <= k; lock clears.
REQ-022 Tag FIFO head selects the result route; resk_tvalid = mult_out_tvalid AND NOT empty AND head==k; resk_tdata = mult_out_tdata for both k.
REQ-023 mult_out_tready = res_head_tready AND NOT empty; head-of-line blocking is required, results are never reordered.
REQ-024 On mult_out handshake: pop tag FIFO.
REQ-025 Occupancy count ranges 0..TAG_DEPTH; simultaneous push and pop leave count unchanged; push is refused when full even if a pop occurs that cycle.
REQ-026 Read and write pointers wrap modulo TAG_DEPTH.
REQ-027 mult_out_tvalid while empty: no result forwarded, mult_out_tready=0, tag_err <= 1 and holds until reset.
REQ-028 Arithmetic: none; data passes bit-exact.

Reset
REQ-029 While n_reset is low at posedge clk: count, rd/wr pointers, lock, and tag_err <= 0; last-grant <= 1, so req0 wins first contention.
REQ-030 While n_reset is low, reqk_tready, resk_tvalid, mult_in_tvalid, and mult_out_tready SHALL be 0.
REQ-031 Reset mid-operation discards all outstanding tags; results returned afterwards set tag_err.

Structure
REQ-032 Shared package caf_arb_pkg holds the tag-width function clog2(TAG_DEPTH), requester index constants REQ0=0 and REQ1=1, and pack/unpack field offsets.
REQ-033 One sub-module, cpx_tag_fifo: synchronous 1-bit-wide FIFO with depth TAG_DEPTH that exposes full, empty, head, and count.

Verification
REQ-034 req0 only, tdata {3,4,1,2} -> mult_in_tdata {3,4,1,2}; the multiplier returns {-5,10}, which appears on res0 only, and res1_tvalid stays 0.
REQ-035 Both requesters valid for 4 cycles after reset, mult_in_tready=1 -> grant sequence is 0,1,0,1.
REQ-036 req0 valid, mult_in_tready=0 for 3 cycles, req1 asserts in cycle 2 -> grant stays 0 and the req0 handshake occurs in cycle 4.
REQ-037 8 accepts with mult_out_tvalid=0 -> count=8 and both reqk_tready=0; one result popped -> the next accept follows in the next cycle.
REQ-038 Outstanding tags 1,0 with res1_tready=0 -> mult_out_tready=0, res0 is not served, and the order is preserved once res1_tready=1.
REQ-039 Reset at count=3, then mult_out_tvalid pulse -> all result valids stay 0 and tag_err=1 until the next reset.

Source files
------------

// File: rtl/cpx_multiply_arbiter_pkg.sv
// Shared constants and helpers for the complex-multiplier arbiter: requester
// indices, tag-width function, arbiter state encoding and stream field offsets.
package caf_arb_pkg;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

  typedef enum logic {
    ARB_OPEN   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

  function automatic int clog2(input int value);
    int v;
    int w;
    v = (value > 1) ? value - 1 : 1;
    w = 0;
    while (v > 0) begin
      w = w + 1;
      v = v >> 1;
    end
    return w;
  endfunction

  // Operand word is {xi, xq, yi, yq}, result word is {i_out, q_out}, MSB first.
  function automatic int xi_lsb(input int data_bits);
    return 3 * data_bits;
  endfunction

  function automatic int xq_lsb(input int data_bits);
    return 2 * data_bits;
  endfunction

  function automatic int yi_lsb(input int data_bits);
    return data_bits;
  endfunction

  function automatic int yq_lsb(input int data_bits);
    return 0 * data_bits;
  endfunction

  function automatic int i_out_lsb(input int out_bits);
    return out_bits;
  endfunction

  function automatic int q_out_lsb(input int out_bits);
    return 0 * out_bits;
  endfunction

endpackage

// File: rtl/cpx_multiply_arbiter_if.sv
// Stream bundle between two requesters, the arbiter and the shared multiplier.
// slave is the arbiter's view; master is the surrounding environment's view.
interface cpx_multiply_arbiter_if #(
  parameter int DATA_BITS = 8,
  parameter int OUT_BITS  = 17
);

  logic                     req0_tvalid;
  logic                     req0_tready;
  logic [4*DATA_BITS-1:0]   req0_tdata;
  logic                     req1_tvalid;
  logic                     req1_tready;
  logic [4*DATA_BITS-1:0]   req1_tdata;

  logic                     res0_tvalid;
  logic                     res0_tready;
  logic [2*OUT_BITS-1:0]    res0_tdata;
  logic                     res1_tvalid;
  logic                     res1_tready;
  logic [2*OUT_BITS-1:0]    res1_tdata;

  logic                     mult_in_tvalid;
  logic                     mult_in_tready;
  logic [4*DATA_BITS-1:0]   mult_in_tdata;
  logic                     mult_out_tvalid;
  logic                     mult_out_tready;
  logic [2*OUT_BITS-1:0]    mult_out_tdata;

  modport slave (
    input  req0_tvalid, req0_tdata, req1_tvalid, req1_tdata,
    output req0_tready, req1_tready,
    output res0_tvalid, res0_tdata, res1_tvalid, res1_tdata,
    input  res0_tready, res1_tready,
    output mult_in_tvalid, mult_in_tdata,
    input  mult_in_tready,
    input  mult_out_tvalid, mult_out_tdata,
    output mult_out_tready
  );

  modport master (
    output req0_tvalid, req0_tdata, req1_tvalid, req1_tdata,
    input  req0_tready, req1_tready,
    input  res0_tvalid, res0_tdata, res1_tvalid, res1_tdata,
    output res0_tready, res1_tready,
    input  mult_in_tvalid, mult_in_tdata,
    output mult_in_tready,
    output mult_out_tvalid, mult_out_tdata,
    input  mult_out_tready
  );

endinterface

// File: rtl/cpx_multiply_arbiter_tag_fifo.sv
// One-bit-wide tag FIFO recording which requester owns each in-flight
// multiplication; pointers wrap naturally because the depth is a power of two.
module cpx_tag_fifo
  import caf_arb_pkg::*;
#(
  parameter int TAG_DEPTH = 8,
  localparam int PTR_W    = clog2(TAG_DEPTH)
) (
  input  logic           clk,
  input  logic           n_reset,
  input  logic           push_i,
  input  logic           din_i,
  input  logic           pop_i,
  output logic           full_o,
  output logic           empty_o,
  output logic           head_o,
  output logic [PTR_W:0] count_o
);

  localparam logic [PTR_W:0]   DEPTH_CNT = (PTR_W + 1)'(TAG_DEPTH);
  localparam logic [PTR_W:0]   CNT_ONE   = (PTR_W + 1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);

  logic [TAG_DEPTH-1:0] mem_q, mem_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]       count_q, count_d;
  logic                 do_push;
  logic                 do_pop;

  assign full_o  = (count_q == DEPTH_CNT);
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // A full FIFO refuses the push even when a pop frees a slot in the same cycle.
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = din_i;
      wr_ptr_d        = wr_ptr_q + PTR_ONE;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      mem_q    <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/cpx_multiply_arbiter.sv
// Round-robin arbiter sharing one complex multiplier between two requesters;
// results return in issue order and are routed by the tag FIFO head.
//
//   state      | meaning
//   ARB_OPEN   | no operand pending; grant chosen round-robin each cycle
//   ARB_LOCKED | operand offered but not taken; grant and data frozen
module cpx_multiply_arbiter
  import caf_arb_pkg::*;
#(
  parameter int DATA_BITS = 8,
  parameter int OUT_BITS  = 17,
  parameter int TAG_DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  n_reset,
  cpx_multiply_arbiter_if.slave bus,
  output logic                  tag_err
);

  localparam int CNT_W = clog2(TAG_DEPTH) + 1;

  arb_state_e             state_q, state_d;
  logic                   grant_q, grant_d;
  logic                   last_q, last_d;
  logic                   tag_err_q, tag_err_d;

  logic                   grant_sel;
  logic                   granted_valid;
  logic                   in_valid;
  logic                   in_fire;
  logic [4*DATA_BITS-1:0] granted_data;

  logic                   head_ready;
  logic                   out_ready;
  logic                   out_fire;
  logic [2*OUT_BITS-1:0]  result_data;

  logic                   fifo_full;
  logic                   fifo_empty;
  logic                   fifo_head;
  logic [CNT_W-1:0]       fifo_count;
  logic                   unused_fifo_count;

  cpx_tag_fifo #(
    .TAG_DEPTH (TAG_DEPTH)
  ) u_tag_fifo (
    .clk     (clk),
    .n_reset (n_reset),
    .push_i  (in_fire),
    .din_i   (grant_sel),
    .pop_i   (out_fire),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .head_o  (fifo_head),
    .count_o (fifo_count)
  );

  // Occupancy is kept for debug visibility only; full/empty drive the logic.
  assign unused_fifo_count = ^fifo_count;

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    last_d    = last_q;
    grant_sel = grant_q;
    if (state_q == ARB_OPEN) begin
      if (bus.req0_tvalid && bus.req1_tvalid) begin
        grant_sel = ~last_q;
      end else if (bus.req0_tvalid) begin
        grant_sel = REQ0;
      end else if (bus.req1_tvalid) begin
        grant_sel = REQ1;
      end else begin
        grant_sel = ~last_q;
      end
    end
    granted_valid = (grant_sel == REQ1) ? bus.req1_tvalid : bus.req0_tvalid;
    granted_data  = (grant_sel == REQ1) ? bus.req1_tdata : bus.req0_tdata;
    in_valid      = n_reset & granted_valid & ~fifo_full;
    in_fire       = in_valid & bus.mult_in_tready;
    if (in_fire) begin
      last_d  = grant_sel;
      state_d = ARB_OPEN;
    end else if (in_valid) begin
      grant_d = grant_sel;
      state_d = ARB_LOCKED;
    end else begin
      state_d = ARB_OPEN;
    end
  end

  assign bus.mult_in_tvalid = in_valid;
  assign bus.mult_in_tdata  = granted_data;
  assign bus.req0_tready    = n_reset & (grant_sel == REQ0) & bus.mult_in_tready & ~fifo_full;
  assign bus.req1_tready    = n_reset & (grant_sel == REQ1) & bus.mult_in_tready & ~fifo_full;

  // Head-of-line: only the requester owning the oldest tag can release the result.
  assign head_ready  = (fifo_head == REQ1) ? bus.res1_tready : bus.res0_tready;
  assign out_ready   = n_reset & ~fifo_empty & head_ready;
  assign out_fire    = bus.mult_out_tvalid & out_ready;
  assign result_data = bus.mult_out_tdata;

  assign bus.mult_out_tready = out_ready;
  assign bus.res0_tvalid     = n_reset & bus.mult_out_tvalid & ~fifo_empty & (fifo_head == REQ0);
  assign bus.res1_tvalid     = n_reset & bus.mult_out_tvalid & ~fifo_empty & (fifo_head == REQ1);
  assign bus.res0_tdata      = result_data;
  assign bus.res1_tdata      = result_data;

  assign tag_err_d = tag_err_q | (bus.mult_out_tvalid & fifo_empty);
  assign tag_err   = tag_err_q;

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      state_q   <= ARB_OPEN;
      grant_q   <= REQ0;
      last_q    <= REQ1;
      tag_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      last_q    <= last_d;
      tag_err_q <= tag_err_d;
    end
  end

endmodule

// File: tb/tb_cpx_multiply_arbiter.sv
// Self-checking bench: directed vector table, hand-written corner sequences and
// a randomized run scored against a queue-based reference model.
module tb_cpx_multiply_arbiter;
  import caf_arb_pkg::*;

  localparam int DB    = 8;
  localparam int OB    = 17;
  localparam int DEPTH = 8;
  localparam int DW    = 4 * DB;
  localparam int RW    = 2 * OB;
  localparam int NROWS = 17;
  localparam int NRAND = 600;

  logic clk;
  logic n_reset;
  logic tag_err;
  int   n_checks = 0;
  int   n_errors = 0;

  cpx_multiply_arbiter_if #(.DATA_BITS(DB), .OUT_BITS(OB)) bus ();

  cpx_multiply_arbiter #(
    .DATA_BITS (DB),
    .OUT_BITS  (OB),
    .TAG_DEPTH (DEPTH)
  ) dut (
    .clk     (clk),
    .n_reset (n_reset),
    .bus     (bus),
    .tag_err (tag_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ctrl = {req0_tvalid, req1_tvalid, mult_in_tready, mult_out_tvalid, res0_tready, res1_tready}
  // e_in = {req0_tready, req1_tready, mult_in_tvalid}; e_out = {mult_out_tready, res0_tvalid, res1_tvalid}
  typedef struct {
    logic [5:0]    ctrl;
    logic [DW-1:0] d0;
    logic [DW-1:0] d1;
    logic [RW-1:0] mod;
    logic [2:0]    e_in;
    logic [DW-1:0] e_mid;
    logic [2:0]    e_out;
  } vec_t;

  vec_t tbl [NROWS];

  function automatic vec_t mkv(input logic [5:0] ctrl, input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                               input logic [RW-1:0] mod, input logic [2:0] e_in,
                               input logic [DW-1:0] e_mid, input logic [2:0] e_out);
    vec_t v;
    v.ctrl = ctrl; v.d0 = d0; v.d1 = d1; v.mod = mod;
    v.e_in = e_in; v.e_mid = e_mid; v.e_out = e_out;
    return v;
  endfunction

  function automatic logic [DW-1:0] pk_op(input int xi, input int xq, input int yi, input int yq);
    logic [DW-1:0] r;
    r = '0;
    r[xi_lsb(DB) +: DB] = xi[DB-1:0];
    r[xq_lsb(DB) +: DB] = xq[DB-1:0];
    r[yi_lsb(DB) +: DB] = yi[DB-1:0];
    r[yq_lsb(DB) +: DB] = yq[DB-1:0];
    return r;
  endfunction

  function automatic logic [RW-1:0] pk_res(input int i_out, input int q_out);
    logic [RW-1:0] r;
    r = '0;
    r[i_out_lsb(OB) +: OB] = i_out[OB-1:0];
    r[q_out_lsb(OB) +: OB] = q_out[OB-1:0];
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_in(input string name, input logic [2:0] e_in, input logic [DW-1:0] e_mid);
    chk({name, "_hs"}, 64'({bus.req0_tready, bus.req1_tready, bus.mult_in_tvalid}), 64'(e_in));
    chk({name, "_mid"}, 64'(bus.mult_in_tdata), 64'(e_mid));
  endtask

  task automatic chk_out(input string name, input logic [2:0] e_out);
    chk({name, "_rs"}, 64'({bus.mult_out_tready, bus.res0_tvalid, bus.res1_tvalid}), 64'(e_out));
  endtask

  task automatic set_in(input logic [5:0] ctrl, input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                        input logic [RW-1:0] mod);
    bus.req0_tvalid     = ctrl[5];
    bus.req1_tvalid     = ctrl[4];
    bus.mult_in_tready  = ctrl[3];
    bus.mult_out_tvalid = ctrl[2];
    bus.res0_tready     = ctrl[1];
    bus.res1_tready     = ctrl[0];
    bus.req0_tdata      = d0;
    bus.req1_tdata      = d1;
    bus.mult_out_tdata  = mod;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    set_in(6'b000000, '0, '0, '0);
    n_reset = 1'b0;
    cyc();
    cyc();
    n_reset = 1'b1;
  endtask

  // Reference model state for the randomized run
  logic          tq [$];
  logic          m_last, m_locked, m_lg;
  logic          v0, v1, mir, mov, s0r, s1r;
  logic [DW-1:0] d0, d1;
  logic [RW-1:0] mod;
  logic [63:0]   r64;
  logic          g, m_full, m_empty, m_head, e_miv, hs_in, hs_out;
  logic [2:0]    e_in, e_out;

  initial begin
    for (int i = 0; i < 4; i++) begin
      tbl[i] = mkv(6'b111000, DW'(32'h1010_1010 + i), DW'(32'h2020_2020 + i), '0,
                   (i % 2 == 0) ? 3'b101 : 3'b011,
                   (i % 2 == 0) ? DW'(32'h1010_1010 + i) : DW'(32'h2020_2020 + i), 3'b000);
    end
    for (int i = 4; i < 8; i++) begin
      tbl[i] = mkv(6'b000111, '0, '0, pk_res(100 * i, -i), 3'b000, '0,
                   (i % 2 == 0) ? 3'b110 : 3'b101);
    end
    tbl[8]  = mkv(6'b101000, pk_op(3, 4, 1, 2), '0, '0, 3'b101, pk_op(3, 4, 1, 2), 3'b000);
    tbl[9]  = mkv(6'b000110, '0, '0, pk_res(-5, 10), 3'b000, '0, 3'b110);
    tbl[10] = mkv(6'b011000, '0, DW'(32'hAABB_CCDD), '0, 3'b011, DW'(32'hAABB_CCDD), 3'b000);
    tbl[11] = mkv(6'b101000, DW'(32'h1122_3344), '0, '0, 3'b101, DW'(32'h1122_3344), 3'b000);
    tbl[12] = mkv(6'b000110, '0, '0, pk_res(7, -7), 3'b000, '0, 3'b001);
    tbl[13] = mkv(6'b000110, '0, '0, pk_res(7, -7), 3'b000, '0, 3'b001);
    tbl[14] = mkv(6'b000111, '0, '0, pk_res(7, -7), 3'b000, '0, 3'b101);
    tbl[15] = mkv(6'b000110, '0, '0, pk_res(-9, 9), 3'b000, '0, 3'b110);
    tbl[16] = mkv(6'b000000, '0, '0, '0, 3'b000, '0, 3'b000);

    // Reset: every handshake output held low even with all inputs active
    n_reset = 1'b0;
    set_in(6'b000000, '0, '0, '0);
    cyc();
    set_in(6'b111111, DW'(32'h5555_5555), DW'(32'h6666_6666), '1);
    @(negedge clk);
    chk("reset_hs", 64'({bus.req0_tready, bus.req1_tready, bus.mult_in_tvalid}), 64'd0);
    chk_out("reset", 3'b000);
    chk("reset_tag_err", 64'(tag_err), 64'd0);
    cyc();
    set_in(6'b000000, '0, '0, '0);
    n_reset = 1'b1;

    // Directed vector table: round-robin, routing, passthrough, head-of-line blocking
    for (int i = 0; i < NROWS; i++) begin
      set_in(tbl[i].ctrl, tbl[i].d0, tbl[i].d1, tbl[i].mod);
      @(negedge clk);
      chk_in($sformatf("tbl%0d", i), tbl[i].e_in, tbl[i].e_mid);
      chk_out($sformatf("tbl%0d", i), tbl[i].e_out);
      chk($sformatf("tbl%0d_res0_data", i), 64'(bus.res0_tdata), 64'(tbl[i].mod));
      chk($sformatf("tbl%0d_res1_data", i), 64'(bus.res1_tdata), 64'(tbl[i].mod));
      cyc();
    end
    chk("tbl_tag_err", 64'(tag_err), 64'd0);

    // Grant lock while mult_in_tready is low
    do_reset();
    set_in(6'b100000, DW'(32'hE0), '0, '0);
    @(negedge clk); chk_in("lock_c1", 3'b001, DW'(32'hE0)); cyc();
    set_in(6'b110000, DW'(32'hE0), DW'(32'hF0), '0);
    @(negedge clk); chk_in("lock_c2", 3'b001, DW'(32'hE0)); cyc();
    @(negedge clk); chk_in("lock_c3", 3'b001, DW'(32'hE0)); cyc();
    set_in(6'b111000, DW'(32'hE0), DW'(32'hF0), '0);
    @(negedge clk); chk_in("lock_c4", 3'b101, DW'(32'hE0)); cyc();
    set_in(6'b011000, '0, DW'(32'hF0), '0);
    @(negedge clk); chk_in("lock_c5", 3'b011, DW'(32'hF0)); cyc();
    set_in(6'b101000, DW'(32'hE1), '0, '0);
    @(negedge clk); chk_in("lock_c6", 3'b101, DW'(32'hE1)); cyc();
    set_in(6'b100000, DW'(32'hE2), '0, '0);
    @(negedge clk); chk_in("lock_c7", 3'b001, DW'(32'hE2)); cyc();
    set_in(6'b110000, DW'(32'hE2), DW'(32'hF1), '0);
    @(negedge clk); chk_in("lock_c8", 3'b001, DW'(32'hE2)); cyc();
    set_in(6'b111000, DW'(32'hE2), DW'(32'hF1), '0);
    @(negedge clk); chk_in("lock_c9", 3'b101, DW'(32'hE2)); cyc();
    set_in(6'b011000, '0, DW'(32'hF1), '0);
    @(negedge clk); chk_in("lock_c10", 3'b011, DW'(32'hF1)); cyc();

    // Fill to capacity, then one pop frees exactly one slot for the next cycle
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      set_in(6'b101000, DW'(32'h100 + i), '0, '0);
      @(negedge clk); chk_in($sformatf("fill%0d", i), 3'b101, DW'(32'h100 + i)); cyc();
    end
    set_in(6'b111000, DW'(32'hAA), DW'(32'hBB), '0);
    @(negedge clk);
    chk_in("full", 3'b000, DW'(32'hBB));
    chk("full_count", 64'(dut.u_tag_fifo.count_o), 64'd8);
    cyc();
    set_in(6'b111111, DW'(32'hAA), DW'(32'hBB), pk_res(1, 2));
    @(negedge clk);
    chk_in("full_pop", 3'b000, DW'(32'hBB));
    chk_out("full_pop", 3'b110);
    cyc();
    set_in(6'b111000, DW'(32'hAA), DW'(32'hBB), '0);
    @(negedge clk);
    chk_in("refill", 3'b011, DW'(32'hBB));
    chk("refill_count", 64'(dut.u_tag_fifo.count_o), 64'd7);
    cyc();

    // Reset with tags outstanding: late result is orphaned and flags tag_err
    do_reset();
    for (int i = 0; i < 3; i++) begin
      set_in(6'b101000, DW'(32'h300 + i), '0, '0);
      cyc();
    end
    set_in(6'b000000, '0, '0, '0);
    @(negedge clk);
    chk("pre_reset_count", 64'(dut.u_tag_fifo.count_o), 64'd3);
    n_reset = 1'b0;
    cyc();
    n_reset = 1'b1;
    set_in(6'b000111, '0, '0, pk_res(-5, 10));
    @(negedge clk);
    chk_out("orphan", 3'b000);
    chk("orphan_err_before", 64'(tag_err), 64'd0);
    cyc();
    set_in(6'b000000, '0, '0, '0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("orphan_err_hold%0d", i), 64'(tag_err), 64'd1);
      chk_out($sformatf("orphan_idle%0d", i), 3'b000);
      cyc();
    end
    do_reset();
    @(negedge clk);
    chk("orphan_err_cleared", 64'(tag_err), 64'd0);

    // Randomized run against the reference model
    do_reset();
    tq.delete();
    m_last = 1'b1; m_locked = 1'b0; m_lg = 1'b0;
    v0 = 1'b0; v1 = 1'b0; mir = 1'b0; mov = 1'b0; s0r = 1'b0; s1r = 1'b0;
    d0 = '0; d1 = '0; mod = '0;
    set_in({v0, v1, mir, mov, s0r, s1r}, d0, d1, mod);
    for (int c = 0; c < NRAND; c++) begin
      @(negedge clk);
      m_full  = (tq.size() == DEPTH);
      m_empty = (tq.size() == 0);
      m_head  = m_empty ? 1'b0 : tq[0];
      if (m_locked)      g = m_lg;
      else if (v0 && v1) g = ~m_last;
      else if (v0)       g = 1'b0;
      else if (v1)       g = 1'b1;
      else               g = ~m_last;
      e_miv  = (g ? v1 : v0) && !m_full;
      e_in   = {(!g && mir && !m_full), (g && mir && !m_full), e_miv};
      e_out  = {(!m_empty && (m_head ? s1r : s0r)),
                (mov && !m_empty && !m_head), (mov && !m_empty && m_head)};
      chk_in($sformatf("rand%0d", c), e_in, g ? d1 : d0);
      chk_out($sformatf("rand%0d", c), e_out);
      hs_in  = e_miv && mir;
      hs_out = mov && e_out[2];
      cyc();
      if (hs_out) void'(tq.pop_front());
      if (hs_in) begin
        tq.push_back(g);
        m_last   = g;
        m_locked = 1'b0;
      end else if (e_miv) begin
        m_locked = 1'b1;
        m_lg     = g;
      end else begin
        m_locked = 1'b0;
      end
      if (hs_in && !g) v0 = 1'b0;
      if (hs_in && g)  v1 = 1'b0;
      if (!v0 && $urandom_range(0, 2) != 0) begin v0 = 1'b1; d0 = DW'($urandom()); end
      if (!v1 && $urandom_range(0, 2) != 0) begin v1 = 1'b1; d1 = DW'($urandom()); end
      mir = ($urandom_range(0, 3) != 0);
      if (!(mov && !hs_out)) begin
        mov = (tq.size() > 0) && ($urandom_range(0, 2) == 0);
        r64 = {$urandom(), $urandom()};
        mod = r64[RW-1:0];
      end
      s0r = ($urandom_range(0, 3) != 0);
      s1r = ($urandom_range(0, 3) != 0);
      set_in({v0, v1, mir, mov, s0r, s1r}, d0, d1, mod);
    end
    @(negedge clk);
    chk("rand_tag_err", 64'(tag_err), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
